// File: rtl/vga_frame_tracker.sv
// Sync edge detection, frame counting and DELAY-stage re-timing of VGA timing signals.
// Start-of-frame/line pulses and frame_no stay cycle-aligned with the delayed sync outputs.
module vga_frame_tracker #(
  parameter int unsigned FRAME_W  = 9,
  parameter int unsigned POS_W    = 10,
  parameter logic        SYNC_ACT = 1'b1,
  parameter int unsigned DELAY    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               display_on_in,
  input  logic [POS_W-1:0]   hpos_in,
  input  logic [POS_W-1:0]   vpos_in,
  input  logic               freeze,
  input  logic               step,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               display_on_out,
  output logic [POS_W-1:0]   hpos_out,
  output logic [POS_W-1:0]   vpos_out,
  output logic               sof,
  output logic               sol,
  output logic [FRAME_W-1:0] frame_no
);

  generate
    if (DELAY < 1 || DELAY > 4) begin : g_bad_delay
      $error("vga_frame_tracker: DELAY must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic             sof;
    logic             sol;
  } stage_t;

  localparam stage_t STAGE_RST = '{
    hsync:      ~SYNC_ACT,
    vsync:      ~SYNC_ACT,
    display_on: 1'b0,
    hpos:       '0,
    vpos:       '0,
    sof:        1'b0,
    sol:        1'b0
  };

  stage_t pipe [DELAY];
  stage_t stage1_c;
  logic   vs_hist;
  logic   hs_hist;
  logic   sof_next_c;
  logic   step_pending;
  logic   step_pending_nxt_c;
  logic   pend_eff_c;
  logic [FRAME_W-1:0] frame_no_nxt_c;

  // Stage 1 payload: raw inputs plus edge detection against last cycle's raw syncs
  always_comb begin
    stage1_c            = STAGE_RST;
    stage1_c.hsync      = hsync_in;
    stage1_c.vsync      = vsync_in;
    stage1_c.display_on = display_on_in;
    stage1_c.hpos       = hpos_in;
    stage1_c.vpos       = vpos_in;
    stage1_c.sof        = (vsync_in == SYNC_ACT) && (vs_hist != SYNC_ACT);
    stage1_c.sol        = (hsync_in == SYNC_ACT) && (hs_hist != SYNC_ACT);
  end

  // History resets to active so a sync already asserted at release makes no pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_hist <= SYNC_ACT;
      hs_hist <= SYNC_ACT;
    end else begin
      vs_hist <= vsync_in;
      hs_hist <= hsync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DELAY; i++) pipe[i] <= STAGE_RST;
    end else begin
      pipe[0] <= stage1_c;
      for (int unsigned i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // sof value about to enter the last stage, so frame_no changes together with sof
  generate
    if (DELAY == 1) begin : g_sof_d1
      assign sof_next_c = stage1_c.sof;
    end else begin : g_sof_dn
      assign sof_next_c = pipe[DELAY-2].sof;
    end
  endgenerate

  assign hsync_out      = pipe[DELAY-1].hsync;
  assign vsync_out      = pipe[DELAY-1].vsync;
  assign display_on_out = pipe[DELAY-1].display_on;
  assign hpos_out       = pipe[DELAY-1].hpos;
  assign vpos_out       = pipe[DELAY-1].vpos;
  assign sof            = pipe[DELAY-1].sof;
  assign sol            = pipe[DELAY-1].sol;

  // A step arriving on the consuming edge counts as already pending
  always_comb begin
    pend_eff_c         = step_pending | step;
    step_pending_nxt_c = pend_eff_c;
    frame_no_nxt_c     = frame_no;
    if (sof_next_c) begin
      if (!freeze) begin
        frame_no_nxt_c = frame_no + FRAME_W'(1);
      end else if (pend_eff_c) begin
        frame_no_nxt_c     = frame_no + FRAME_W'(1);
        step_pending_nxt_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_no     <= '0;
      step_pending <= 1'b0;
    end else begin
      frame_no     <= frame_no_nxt_c;
      step_pending <= step_pending_nxt_c;
    end
  end

endmodule

// File: tb/tb_vga_frame_tracker.sv
// Directed bench for vga_frame_tracker: DELAY=1 and DELAY=3 instances driven from shared inputs.
module tb_vga_frame_tracker;

  localparam int unsigned FW = 9;
  localparam int unsigned PW = 10;
  localparam int unsigned VW = 2 * PW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsync_in, vsync_in, display_on_in, freeze, step;
  logic [PW-1:0] hpos_in, vpos_in;

  logic          a_hs, a_vs, a_de, a_sof, a_sol;
  logic [PW-1:0] a_hp, a_vp;
  logic [FW-1:0] a_frame;
  logic          b_hs, b_vs, b_de, b_sof, b_sol;
  logic [PW-1:0] b_hp, b_vp;
  logic [FW-1:0] b_frame;

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] hist [3];
  int a_pipe_err = 0, b_pipe_err = 0, a_sol_err = 0, b_sol_err = 0;
  int a_sof_cnt = 0, b_sof_cnt = 0, a_sol_cnt = 0, b_sol_cnt = 0;
  logic a_hs_prev = 1'b0, b_hs_prev = 1'b0;
  int base_a_sof, base_b_sof, base_a_sol, base_b_sol;

  always #5 clk = ~clk;

  vga_frame_tracker #(.FRAME_W(FW), .POS_W(PW), .SYNC_ACT(1'b1), .DELAY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on_in(display_on_in), .hpos_in(hpos_in), .vpos_in(vpos_in),
    .freeze(freeze), .step(step), .hsync_out(a_hs), .vsync_out(a_vs),
    .display_on_out(a_de), .hpos_out(a_hp), .vpos_out(a_vp),
    .sof(a_sof), .sol(a_sol), .frame_no(a_frame));

  vga_frame_tracker #(.FRAME_W(FW), .POS_W(PW), .SYNC_ACT(1'b1), .DELAY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on_in(display_on_in), .hpos_in(hpos_in), .vpos_in(vpos_in),
    .freeze(freeze), .step(step), .hsync_out(b_hs), .vsync_out(b_vs),
    .display_on_out(b_de), .hpos_out(b_hp), .vpos_out(b_vp),
    .sof(b_sof), .sol(b_sol), .frame_no(b_frame));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    a_hs_prev = 1'b0;
    b_hs_prev = 1'b0;
  endtask

  // Drive one pixel, clock it in, and track alignment/latency of both instances
  task automatic px(input logic h, input logic v, input logic d,
                    input logic [PW-1:0] hp, input logic [PW-1:0] vp);
    hsync_in = h; vsync_in = v; display_on_in = d; hpos_in = hp; vpos_in = vp;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {h, v, d, hp, vp};
    @(posedge clk);
    #1;
    if ({a_hs, a_vs, a_de, a_hp, a_vp} !== hist[0]) a_pipe_err++;
    if ({b_hs, b_vs, b_de, b_hp, b_vp} !== hist[2]) b_pipe_err++;
    if (a_sol !== (a_hs && !a_hs_prev)) a_sol_err++;
    if (b_sol !== (b_hs && !b_hs_prev)) b_sol_err++;
    a_hs_prev = a_hs;
    b_hs_prev = b_hs;
    a_sof_cnt += int'(a_sof);
    b_sof_cnt += int'(b_sof);
    a_sol_cnt += int'(a_sol);
    b_sol_cnt += int'(b_sol);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One-cycle vsync pulse plus enough idle cycles to flush the deeper pipeline
  task automatic frame_pulse();
    px(1'b0, 1'b1, 1'b0, '0, '0);
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b1; display_on_in = 1'b0;
    hpos_in = '0; vpos_in = '0; freeze = 1'b0; step = 1'b0;
    clear_hist();
    #23;
    check("rst_a_vec",   32'({a_hs, a_vs, a_de, a_hp, a_vp}), 32'd0);
    check("rst_b_vec",   32'({b_hs, b_vs, b_de, b_hp, b_vp}), 32'd0);
    check("rst_a_frame", 32'(a_frame), 32'd0);
    check("rst_b_pulse", 32'({b_sof, b_sol}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // vsync active across release: no pulse, then a real edge
    for (int k = 0; k < 5; k++) px(1'b0, 1'b1, 1'b0, '0, '0);
    check("held_vs_sof_a", 32'(a_sof_cnt), 32'd0);
    check("held_vs_sof_b", 32'(b_sof_cnt), 32'd0);
    idle(10);
    px(1'b0, 1'b1, 1'b0, '0, '0);
    check("edge1_a_sof",   32'(a_sof), 32'd1);
    check("edge1_a_frame", 32'(a_frame), 32'd1);
    check("edge1_b_sof",   32'(b_sof), 32'd0);
    px(1'b0, 1'b1, 1'b0, '0, '0);
    check("edge2_a_sof",   32'(a_sof), 32'd0);
    check("edge2_b_frame", 32'(b_frame), 32'd0);
    px(1'b0, 1'b1, 1'b0, '0, '0);
    check("edge3_b_sof",   32'(b_sof), 32'd1);
    check("edge3_b_frame", 32'(b_frame), 32'd1);
    idle(2);
    check("first_sof_cnt", 32'({a_sof_cnt[15:0], b_sof_cnt[15:0]}), {16'd1, 16'd1});

    // Scaled raster: 8 px/line, hsync 2 px, 5 lines/frame, vsync on line 0
    base_a_sof = a_sof_cnt; base_b_sof = b_sof_cnt;
    base_a_sol = a_sol_cnt; base_b_sol = b_sol_cnt;
    for (int f = 0; f < 4; f++)
      for (int ln = 0; ln < 5; ln++)
        for (int x = 0; x < 8; x++)
          px(x < 2, ln == 0, x < 6, PW'(x + 16 * f), PW'(ln));
    idle(4);
    check("raster_sof_a", 32'(a_sof_cnt - base_a_sof), 32'd4);
    check("raster_sof_b", 32'(b_sof_cnt - base_b_sof), 32'd4);
    check("raster_sol_a", 32'(a_sol_cnt - base_a_sol), 32'd20);
    check("raster_sol_b", 32'(b_sol_cnt - base_b_sol), 32'd20);
    check("raster_frame_a", 32'(a_frame), 32'd5);
    check("raster_frame_b", 32'(b_frame), 32'd5);
    check("pipe_a", 32'(a_pipe_err), 32'd0);
    check("pipe_b", 32'(b_pipe_err), 32'd0);
    check("sol_align_a", 32'(a_sol_err), 32'd0);
    check("sol_align_b", 32'(b_sol_err), 32'd0);

    // Wrap-around
    for (int i = 0; i < 506; i++) frame_pulse();
    check("max_frame_a", 32'(a_frame), 32'd511);
    check("max_frame_b", 32'(b_frame), 32'd511);
    frame_pulse();
    check("wrap_frame_a", 32'(a_frame), 32'd0);
    check("wrap_frame_b", 32'(b_frame), 32'd0);

    // Freeze, single step, and collapse of repeated steps
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) frame_pulse();
    check("frozen_a", 32'(a_frame), 32'd0);
    check("frozen_b", 32'(b_frame), 32'd0);
    step = 1'b1; idle(1); step = 1'b0; idle(1);
    frame_pulse();
    check("step1_a", 32'(a_frame), 32'd1);
    check("step1_b", 32'(b_frame), 32'd1);
    frame_pulse(); frame_pulse();
    check("step1_hold", 32'({a_frame, 7'd0, b_frame}), {9'd1, 7'd0, 9'd1});
    step = 1'b1; idle(1); step = 1'b0; idle(1);
    step = 1'b1; idle(1); step = 1'b0; idle(1);
    frame_pulse();
    check("collapse_a", 32'(a_frame), 32'd2);
    frame_pulse();
    check("collapse_hold_a", 32'(a_frame), 32'd2);
    check("collapse_hold_b", 32'(b_frame), 32'd2);

    // Step in the same cycle stage 1 sees the vsync edge
    step = 1'b1;
    px(1'b0, 1'b1, 1'b0, '0, '0);
    step = 1'b0;
    idle(3);
    check("same_edge_a", 32'(a_frame), 32'd3);
    check("same_edge_b", 32'(b_frame), 32'd3);
    frame_pulse();
    check("same_edge_hold_a", 32'(a_frame), 32'd3);
    check("same_edge_hold_b", 32'(b_frame), 32'd3);

    // Step while running stays pending until frozen
    freeze = 1'b0;
    step = 1'b1; idle(1); step = 1'b0;
    frame_pulse();
    check("run_step_a", 32'(a_frame), 32'd4);
    freeze = 1'b1;
    frame_pulse();
    check("late_step_a", 32'(a_frame), 32'd5);
    check("late_step_b", 32'(b_frame), 32'd5);
    frame_pulse();
    check("late_step_hold_b", 32'(b_frame), 32'd5);

    // Asynchronous reset between clock edges, with a pending step outstanding
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) px(1'b1, 1'b1, 1'b1, 10'h155, 10'h2AA);
    freeze = 1'b1; step = 1'b1;
    px(1'b1, 1'b1, 1'b1, 10'h155, 10'h2AA);
    step = 1'b0;
    #2;
    rst_n = 1'b0;
    hsync_in = 1'b0; display_on_in = 1'b0;
    #1;
    check("async_a_vec",   32'({a_hs, a_vs, a_de, a_hp, a_vp}), 32'd0);
    check("async_b_vec",   32'({b_hs, b_vs, b_de, b_hp, b_vp}), 32'd0);
    check("async_frames",  32'({a_frame, 7'd0, b_frame}), 32'd0);
    check("async_pulses",  32'({a_sof, a_sol, b_sof, b_sol}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_hist();
    base_a_sof = a_sof_cnt; base_b_sof = b_sof_cnt;
    for (int k = 0; k < 3; k++) px(1'b0, 1'b1, 1'b0, '0, '0);
    idle(3);
    check("post_rst_sof_a", 32'(a_sof_cnt - base_a_sof), 32'd0);
    check("post_rst_sof_b", 32'(b_sof_cnt - base_b_sof), 32'd0);
    frame_pulse();
    check("pend_cleared_a", 32'(a_frame), 32'd0);
    check("pend_cleared_b", 32'(b_frame), 32'd0);
    freeze = 1'b0;
    frame_pulse();
    check("post_rst_frame_a", 32'(a_frame), 32'd1);
    check("post_rst_frame_b", 32'(b_frame), 32'd1);
    check("final_pipe", 32'(a_pipe_err + b_pipe_err), 32'd0);
    check("final_sol_align", 32'(a_sol_err + b_sol_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
